// File: rtl/numerator_request_arbiter.sv
// numerator_request_arbiter
// Front end of the clinic numerator. It synchronizes and edge-detects four raw
// push-buttons and holds each press as a pending request. A round-robin
// arbiter grants one pending request per cycle. Each grant is checked against
// a shadow occupancy count of its clinic: a legal grant becomes a single-cycle
// command (en, clinic, mode), and an illegal one is dropped with a reject pulse.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   btn_ticket0/1     raw patient ticket buttons for clinic 0/1
//   btn_call0/1       raw doctor call-next buttons for clinic 0/1
//   en                one-cycle command strobe
//   clinic            command target clinic, held while en=0
//   mode              1 = delete (call next), 0 = insert (ticket), held while en=0
//   reject            one-cycle pulse when a granted request was illegal
//   lost              one-cycle pulse when a press hit an already pending source
//   count0/1          shadow occupancy per clinic, 0..DEPTH
module numerator_request_arbiter #(
    parameter int DEPTH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ticket0,
    input  logic       btn_ticket1,
    input  logic       btn_call0,
    input  logic       btn_call1,
    output logic       en,
    output logic       clinic,
    output logic       mode,
    output logic       reject,
    output logic       lost,
    output logic [3:0] count0,
    output logic [3:0] count1
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    // Source index: bit 0 selects the clinic, bit 1 selects delete.
    logic [3:0] btn_raw;
    assign btn_raw = {btn_call1, btn_call0, btn_ticket1, btn_ticket0};

    logic [3:0]      s1_q, s2_q, s3_q;
    logic [3:0]      pend_q, pend_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            clinic_q, clinic_d;
    logic            mode_q, mode_d;
    logic            reject_q, reject_d;
    logic            lost_q, lost_d;

    logic [3:0] press;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_oh;
    logic       gnt_clinic;
    logic       gnt_del;
    logic [3:0] gnt_cnt;
    logic       legal;

    assign press = s2_q & ~s3_q;

    // Round-robin search. Walk from the farthest offset back to the pointer so
    // that the nearest pending source, starting at the pointer, wins.
    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_clinic = gnt_idx[0];
    assign gnt_del    = gnt_idx[1];
    assign gnt_cnt    = cnt_q[gnt_clinic];
    assign legal      = gnt_del ? (gnt_cnt != 4'd0) : (gnt_cnt < DEPTH_C);
    assign gnt_oh     = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        // A press on the source being granted this cycle re-arms its bit,
        // so it is kept rather than counted as lost.
        pend_d   = (pend_q & ~gnt_oh) | press;
        lost_d   = |(press & pend_q & ~gnt_oh);
        ptr_d    = gnt_vld ? gnt_idx + 2'd1 : ptr_q;
        en_d     = gnt_vld & legal;
        reject_d = gnt_vld & ~legal;
        clinic_d = clinic_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        if (gnt_vld && legal) begin
            clinic_d = gnt_clinic;
            mode_d   = gnt_del;
            cnt_d[gnt_clinic] = gnt_del ? gnt_cnt - 4'd1 : gnt_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            pend_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            clinic_q <= 1'b0;
            mode_q   <= 1'b0;
            reject_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            clinic_q <= clinic_d;
            mode_q   <= mode_d;
            reject_q <= reject_d;
            lost_q   <= lost_d;
        end
    end

    assign en     = en_q;
    assign clinic = clinic_q;
    assign mode   = mode_q;
    assign reject = reject_q;
    assign lost   = lost_q;
    assign count0 = cnt_q[0];
    assign count1 = cnt_q[1];

endmodule

// File: tb/tb_numerator_request_arbiter.sv
module tb_numerator_request_arbiter;
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_ticket0 = 1'b0, btn_ticket1 = 1'b0, btn_call0 = 1'b0, btn_call1 = 1'b0;
    logic en, clinic, mode, reject, lost;
    logic [3:0] count0, count1;

    numerator_request_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_ticket0(btn_ticket0), .btn_ticket1(btn_ticket1),
        .btn_call0(btn_call0), .btn_call1(btn_call1),
        .en(en), .clinic(clinic), .mode(mode), .reject(reject), .lost(lost),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        logic [12:0] v;   // {en, reject, lost, clinic, mode, count0, count1}
    } exp_t;

    exp_t sb[$];
    int tests = 0, fails = 0;
    int edge_no = 0;
    int en_seen = 0, rej_seen = 0, lost_seen = 0;

    // Reference model state: what is waiting, whose turn it is, clinic fill.
    int m_pend[4], m_ptr, m_cnt[2], m_clinic, m_mode;
    int h1[4], h2[4], h3[4];   // button level seen at the last three edges

    task automatic chk(string nm, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, got, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_pend[s] = 0; h1[s] = 0; h2[s] = 0; h3[s] = 0;
        end
        m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_clinic = 0; m_mode = 0;
    endtask

    // One clock edge of the model, with button levels b as sampled at that edge.
    task automatic model_step(input logic [3:0] b);
        int ev[4];
        int g, e_en, e_rej, e_lost, c;
        exp_t x;
        // A press counts once its level has been seen high for two edges after low.
        for (int s = 0; s < 4; s++) ev[s] = (h2[s] == 1 && h3[s] == 0) ? 1 : 0;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && m_pend[(m_ptr + k) % 4] == 1) g = (m_ptr + k) % 4;
        e_en = 0; e_rej = 0; e_lost = 0;
        if (g >= 0) begin
            c = g % 2;
            if (g >= 2) begin
                if (m_cnt[c] > 0) begin e_en = 1; m_cnt[c]--; end else e_rej = 1;
            end else begin
                if (m_cnt[c] < DEPTH) begin e_en = 1; m_cnt[c]++; end else e_rej = 1;
            end
            if (e_en == 1) begin m_clinic = c; m_mode = (g >= 2) ? 1 : 0; end
            m_pend[g] = 0;
            m_ptr = (g + 1) % 4;
        end
        for (int s = 0; s < 4; s++) begin
            if (ev[s] == 1) begin
                if (m_pend[s] == 1) e_lost = 1;
                m_pend[s] = 1;
            end
            h3[s] = h2[s]; h2[s] = h1[s]; h1[s] = int'(b[s]);
        end
        if (e_en + e_rej + e_lost > 0) begin
            x.cyc = edge_no + 1;
            x.v = {1'(e_en), 1'(e_rej), 1'(e_lost), 1'(m_clinic), 1'(m_mode),
                   4'(m_cnt[0]), 4'(m_cnt[1])};
            sb.push_back(x);
        end
    endtask

    // Called at a falling edge; ends at the next falling edge.
    task automatic tick(input logic [3:0] b);
        {btn_call1, btn_call0, btn_ticket1, btn_ticket0} = b;
        if (rst_n) model_step(b); else model_reset();
        @(posedge clk);
        edge_no++;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int idle);
        for (int i = 0; i < hold; i++) tick(b);
        for (int i = 0; i < idle; i++) tick(4'b0000);
    endtask

    // Monitor: compares whenever the DUT strobes or an expected event falls due.
    always @(posedge clk) begin
        exp_t x;
        logic [12:0] got;
        #1;
        got = {en, reject, lost, clinic, mode, count0, count1};
        if (en) en_seen++;
        if (reject) rej_seen++;
        if (lost) lost_seen++;
        if (sb.size() > 0 && sb[0].cyc == edge_no) begin
            x = sb.pop_front();
            tests++;
            if (got !== x.v) begin
                fails++;
                $display("FAIL event@%0d: got {en,rej,lost,cl,md,c0,c1}=%b_%b_%b_%b_%b_%0d_%0d, expected %b_%b_%b_%b_%b_%0d_%0d",
                         edge_no, got[12], got[11], got[10], got[9], got[8], got[7:4], got[3:0],
                         x.v[12], x.v[11], x.v[10], x.v[9], x.v[8], x.v[7:4], x.v[3:0]);
            end
        end else if (rst_n && (en || reject || lost)) begin
            tests++;
            fails++;
            $display("FAIL unexpected event@%0d: en=%b reject=%b lost=%b, expected none",
                     edge_no, en, reject, lost);
        end
    end

    task automatic chk_zero(string nm);
        chk({nm, ".en"}, int'(en), 0);
        chk({nm, ".reject"}, int'(reject), 0);
        chk({nm, ".lost"}, int'(lost), 0);
        chk({nm, ".clinic"}, int'(clinic), 0);
        chk({nm, ".mode"}, int'(mode), 0);
        chk({nm, ".count0"}, int'(count0), 0);
        chk({nm, ".count1"}, int'(count1), 0);
    endtask

    initial begin
        int e0, r0, l0;
        logic [3:0] b;
        model_reset();
        #1;
        chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single held ticket0: one insert into clinic 0.
        e0 = en_seen; l0 = lost_seen;
        press(4'b0001, 10, 8);
        chk("t1.count0", int'(count0), 1);
        chk("t1.en_pulses", en_seen - e0, 1);
        chk("t1.lost", lost_seen - l0, 0);

        // Call on an empty clinic 1 is rejected.
        e0 = en_seen; r0 = rej_seen;
        press(4'b1000, 2, 8);
        chk("t2.reject", rej_seen - r0, 1);
        chk("t2.en", en_seen - e0, 0);
        chk("t2.count1", int'(count1), 0);

        // Six tickets into clinic 1: the sixth overflows.
        e0 = en_seen; r0 = rej_seen;
        for (int i = 0; i < 6; i++) press(4'b0010, 2, 6);
        chk("t3.count1", int'(count1), DEPTH);
        chk("t3.en", en_seen - e0, 5);
        chk("t3.reject", rej_seen - r0, 1);

        // Bring both clinics to 2, then press all four together.
        press(4'b0001, 2, 6);
        for (int i = 0; i < 3; i++) press(4'b1000, 2, 6);
        chk("t4.pre_count0", int'(count0), 2);
        chk("t4.pre_count1", int'(count1), 2);
        e0 = en_seen;
        press(4'b1111, 2, 8);
        chk("t4.en", en_seen - e0, 4);
        chk("t4.count0", int'(count0), 2);
        chk("t4.count1", int'(count1), 2);

        // Move the pointer past ticket0, then double-press ticket0 while it waits.
        press(4'b0001, 2, 6);
        l0 = lost_seen;
        tick(4'b1111); tick(4'b1110); tick(4'b1111);
        press(4'b0000, 0, 10);
        chk("t5.lost", lost_seen - l0, 1);
        chk("t5.count0", int'(count0), 3);
        chk("t5.count1", int'(count1), 2);

        // Asynchronous reset with requests pending and ticket0 held through release.
        for (int i = 0; i < 3; i++) tick(4'b1011);
        chk("t6.pre_count0", int'(count0), 3);
        rst_n = 1'b0;
        #1;
        chk_zero("t6.async");
        sb.delete();
        for (int i = 0; i < 3; i++) tick(4'b0001);
        rst_n = 1'b1;
        e0 = en_seen;
        press(4'b0001, 5, 8);
        chk("t6.en_after", en_seen - e0, 1);
        chk("t6.count0", int'(count0), 1);
        chk("t6.count1", int'(count1), 0);

        // Randomized button activity.
        b = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 5) == 0) b[s] = ~b[s];
            tick(b);
        end
        press(4'b0000, 0, 12);
        chk("final.sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
